// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot-load controller.
package imem_boot_pkg;

  typedef enum logic [2:0] {
    ST_LEN  = 3'd0,
    ST_DATA = 3'd1,
    ST_CSUM = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } boot_state_t;

  localparam int unsigned BOOT_LEN_BYTES = 4;

endpackage

// File: rtl/imem_boot_ctrl.sv
// Boot-load controller: length-prefixed byte stream -> instruction memory writes, core held until done.
// Optional trailing XOR checksum byte enabled by defining IMEM_BOOT_CSUM_EN.
module imem_boot_ctrl
  import imem_boot_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              error
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

`ifdef IMEM_BOOT_CSUM_EN
  localparam boot_state_t PAYLOAD_END_ST = ST_CSUM;
`else
  localparam boot_state_t PAYLOAD_END_ST = ST_RUN;
`endif

  boot_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       len_q, len_d;
  logic [7:0]        csum_q, csum_d;
  logic              we_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [7:0]        wdata_d;
  logic              rx_ready_d, cpu_hold_d, load_done_d, error_d;
  logic              accept;
  logic [31:0]       len_new;

  assign accept  = rx_valid && rx_ready;
  // Little-endian assembly: each new byte lands on top, earlier bytes shift down.
  assign len_new = {rx_data, len_q[31:8]};

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_LEN;
    else       state_q <= state_d;
  end

  // Next-state, datapath and next-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    waddr_d = mem_waddr;
    wdata_d = mem_wdata;

    case (state_q)
      ST_LEN: begin
        if (accept) begin
          len_d = len_new;
          if (cnt_q == CNT_W'(BOOT_LEN_BYTES - 1)) begin
            cnt_d = '0;
            if (len_new > 32'(DEPTH))   state_d = ST_ERR;
            else if (len_new == 32'd0)  state_d = PAYLOAD_END_ST;
            else                        state_d = ST_DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = cnt_q[ADDR_W-1:0];
          wdata_d = rx_data;
          csum_d  = csum_q ^ rx_data;
          cnt_d   = cnt_q + CNT_W'(1);
          if (32'(cnt_q) + 32'd1 == len_q) state_d = PAYLOAD_END_ST;
        end
      end
`ifdef IMEM_BOOT_CSUM_EN
      ST_CSUM: begin
        if (accept) state_d = (rx_data == csum_q) ? ST_RUN : ST_ERR;
      end
`endif
      ST_RUN, ST_ERR: begin
        if (reload) begin
          state_d = ST_LEN;
          cnt_d   = '0;
          len_d   = '0;
          csum_d  = '0;
        end
      end
      default: state_d = ST_LEN;
    endcase

    // Outputs are registered copies of what the next state/strobe implies.
    rx_ready_d  = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
    cpu_hold_d  = !((state_d == ST_RUN) && !we_d);
    load_done_d = (state_d == ST_RUN);
    error_d     = (state_d == ST_ERR);
  end

  // Datapath and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      len_q     <= '0;
      csum_q    <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      rx_ready  <= 1'b1;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      error     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      csum_q    <= csum_d;
      mem_we    <= we_d;
      mem_waddr <= waddr_d;
      mem_wdata <= wdata_d;
      rx_ready  <= rx_ready_d;
      cpu_hold  <= cpu_hold_d;
      load_done <= load_done_d;
      error     <= error_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl; expected memory writes are queued at byte accept
// and matched against the write port. Follows IMEM_BOOT_CSUM_EN if defined.
module tb_imem_boot_ctrl;

  localparam int unsigned ADDR_W = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              reload = 1'b0;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              error;

  int          checks = 0;
  int          failures = 0;
  int          nwrites = 0;
  int unsigned exp_q[$];
  logic [7:0]  pay [16];
  logic [7:0]  x;

  imem_boot_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .reload    (reload),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .error     (error)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Write-port monitor: every strobe must match the oldest queued expectation.
  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      int unsigned e;
      nwrites++;
      check_eq("wr_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("wr_addr", 32'(mem_waddr), e >> 8);
        check_eq("wr_data", 32'(mem_wdata), e & 32'hFF);
      end
    end
  end

  task automatic idle();
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit expect_write, input int unsigned addr);
    int n = 0;
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) begin
      check_eq("rx_ready_timeout", 32'(rx_ready), 32'd1);
    end else if (expect_write) begin
      exp_q.push_back((addr << 8) | 32'(b));
    end
    @(posedge clock);
  endtask

  task automatic send_len(input int unsigned len);
    for (int i = 0; i < 4; i++) send_byte(8'(len >> (8 * i)), 1'b0, 0);
  endtask

  task automatic send_payload(input int unsigned n, input bit gap, output logic [7:0] cs);
    cs = 8'h00;
    for (int k = 0; k < int'(n); k++) begin
      send_byte(pay[k], 1'b1, k);
      cs = cs ^ pay[k];
      if (gap) idle();
    end
  endtask

  task automatic pulse_reload();
    @(negedge clock);
    reload = 1'b1;
    @(negedge clock);
    reload = 1'b0;
  endtask

  task automatic end_test(input string tag, input int exp_writes);
    @(negedge clock);
    @(negedge clock);
    check_eq({tag, "_nwrites"}, 32'(nwrites), 32'(exp_writes));
    check_eq({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    nwrites = 0;
  endtask

  initial begin
    // Reset values
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_eq("rst_rx_ready", 32'(rx_ready), 32'd1);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_waddr", 32'(mem_waddr), 32'd0);
    check_eq("rst_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check_eq("rst_load_done", 32'(load_done), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    nwrites = 0;

    // L=4, payload 11 22 33 44, checksum 44
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    send_len(4);
    send_payload(4, 1'b0, x);
`ifdef IMEM_BOOT_CSUM_EN
    send_byte(x, 1'b0, 0);
    idle();
    check_eq("t1_load_done", 32'(load_done), 32'd1);
    check_eq("t1_cpu_hold", 32'(cpu_hold), 32'd0);
`else
    idle();
    check_eq("t1_last_we", 32'(mem_we), 32'd1);
    check_eq("t1_hold_during_we", 32'(cpu_hold), 32'd1);
    check_eq("t1_load_done", 32'(load_done), 32'd1);
    @(negedge clock);
    check_eq("t1_we_off", 32'(mem_we), 32'd0);
    check_eq("t1_cpu_hold", 32'(cpu_hold), 32'd0);
`endif
    check_eq("t1_error", 32'(error), 32'd0);
    check_eq("t1_rx_ready", 32'(rx_ready), 32'd0);
    // Bytes offered in RUN are ignored
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    repeat (3) @(negedge clock);
    rx_valid = 1'b0;
    check_eq("t1_run_still", 32'(load_done), 32'd1);
    end_test("t1", 4);

    // L=17 overflows a 16-byte memory
    pulse_reload();
    check_eq("t2_reload_ready", 32'(rx_ready), 32'd1);
    send_len(17);
    idle();
    check_eq("t2_error", 32'(error), 32'd1);
    check_eq("t2_rx_ready", 32'(rx_ready), 32'd0);
    check_eq("t2_cpu_hold", 32'(cpu_hold), 32'd1);
    check_eq("t2_load_done", 32'(load_done), 32'd0);
    end_test("t2", 0);
    pulse_reload();
    check_eq("t2_rel_error", 32'(error), 32'd0);
    check_eq("t2_rel_ready", 32'(rx_ready), 32'd1);

    // L=2, payload AA 55, wrong checksum 00
    pay[0] = 8'hAA; pay[1] = 8'h55;
    send_len(2);
    send_payload(2, 1'b0, x);
`ifdef IMEM_BOOT_CSUM_EN
    check_eq("t3_csum_model", 32'(x), 32'hFF);
    send_byte(8'h00, 1'b0, 0);
    idle();
    @(negedge clock);
    check_eq("t3_error", 32'(error), 32'd1);
    check_eq("t3_cpu_hold", 32'(cpu_hold), 32'd1);
    check_eq("t3_rx_ready", 32'(rx_ready), 32'd0);
`else
    idle();
    @(negedge clock);
    check_eq("t3_load_done", 32'(load_done), 32'd1);
    check_eq("t3_cpu_hold", 32'(cpu_hold), 32'd0);
`endif
    end_test("t3", 2);
    pulse_reload();
    check_eq("t3_rel_ready", 32'(rx_ready), 32'd1);
    check_eq("t3_rel_error", 32'(error), 32'd0);
    check_eq("t3_rel_hold", 32'(cpu_hold), 32'd1);
    check_eq("t3_rel_done", 32'(load_done), 32'd0);

    // L=16 full depth with rx_valid toggling
    for (int k = 0; k < 16; k++) pay[k] = 8'(k);
    send_len(16);
    send_payload(16, 1'b1, x);
`ifdef IMEM_BOOT_CSUM_EN
    send_byte(x, 1'b0, 0);
    idle();
`endif
    @(negedge clock);
    check_eq("t4_load_done", 32'(load_done), 32'd1);
    check_eq("t4_error", 32'(error), 32'd0);
    check_eq("t4_cpu_hold", 32'(cpu_hold), 32'd0);
    end_test("t4", 16);

    // Reset after 2 of 4 payload bytes; third byte coincides with reset and is dropped
    pulse_reload();
    pay[0] = 8'hA0; pay[1] = 8'hA1;
    send_len(4);
    send_payload(2, 1'b0, x);
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = 8'hA2;
    reset    = 1'b1;
    @(negedge clock);
    reset    = 1'b0;
    rx_valid = 1'b0;
    check_eq("t5_we_dropped", 32'(mem_we), 32'd0);
    check_eq("t5_rx_ready", 32'(rx_ready), 32'd1);
    check_eq("t5_cpu_hold", 32'(cpu_hold), 32'd1);
    check_eq("t5_load_done", 32'(load_done), 32'd0);
    pay[0] = 8'h5A;
    send_len(1);
    send_payload(1, 1'b0, x);
`ifdef IMEM_BOOT_CSUM_EN
    send_byte(x, 1'b0, 0);
`endif
    idle();
    @(negedge clock);
    check_eq("t5_load_done2", 32'(load_done), 32'd1);
    end_test("t5", 3);

    // L=0: no writes
    pulse_reload();
    send_len(0);
`ifdef IMEM_BOOT_CSUM_EN
    send_byte(8'h00, 1'b0, 0);
`endif
    idle();
    check_eq("t6_load_done", 32'(load_done), 32'd1);
    check_eq("t6_cpu_hold", 32'(cpu_hold), 32'd0);
    check_eq("t6_mem_we", 32'(mem_we), 32'd0);
    end_test("t6", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
